// File: rtl/tail_light_pkg.sv
// ----------------------------------------------------------------------------
// tail_light_pkg
//   Shared encodings for the rear-lamp controller.
//   - Brake FSM state codes (IDLE, ACTIVE, HOLD).
//   - Lamp sequencer mode codes (OFF, LEFT, RIGHT, HAZ).
//   - cnt_width(): the number of bits needed to hold a counter's maximum
//     value, never less than 1.
// ----------------------------------------------------------------------------
package tail_light_pkg;

  // Brake FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Sequencer modes
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_LEFT  = 2'd1;
  localparam logic [1:0] MODE_RIGHT = 2'd2;
  localparam logic [1:0] MODE_HAZ   = 2'd3;

  // Bits needed to represent 0..max_val, with a floor of one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/turn_sequencer.sv
// ----------------------------------------------------------------------------
// turn_sequencer
//   Produces the turn-signal and hazard patterns for both side banks.
//   - Decodes the request inputs into a mode. Hazard has priority, and
//     left+right together also counts as hazard.
//   - A prescaler divides clk into sequencer steps.
//   - A phase counter advances once per step. Any mode change restarts the
//     prescaler and the phase from zero.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   left_turn           left indicator request
//   right_turn          right indicator request
//   hazard              hazard request
//   l_pat, r_pat        unbraked lamp patterns, bit0 = innermost lamp
// ----------------------------------------------------------------------------
module turn_sequencer
  import tail_light_pkg::*;
#(
  parameter int N_SIDE   = 3,
  parameter int STEP_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              left_turn,
  input  logic              right_turn,
  input  logic              hazard,
  output logic [N_SIDE-1:0] l_pat,
  output logic [N_SIDE-1:0] r_pat
);

  localparam int PW  = cnt_width(STEP_DIV - 1);
  localparam int PHW = cnt_width(N_SIDE);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(STEP_DIV - 1);
  localparam logic [PHW-1:0] PHASE_MAX = PHW'(N_SIDE);

  logic [1:0]        mode_next;
  logic [1:0]        mode_reg;
  logic [PW-1:0]     presc_reg;
  logic [PHW-1:0]    phase_reg;
  logic              tick;
  logic [N_SIDE-1:0] sweep;
  logic [N_SIDE-1:0] all_on;

  always_comb begin
    mode_next = MODE_OFF;
    if (hazard || (left_turn && right_turn)) mode_next = MODE_HAZ;
    else if (left_turn)                      mode_next = MODE_LEFT;
    else if (right_turn)                     mode_next = MODE_RIGHT;
  end

  assign tick = (presc_reg == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg  <= MODE_OFF;
      presc_reg <= '0;
      phase_reg <= '0;
    end else begin
      mode_reg <= mode_next;
      // A new mode (or idling in OFF) restarts the pattern from phase 0.
      if ((mode_next != mode_reg) || (mode_next == MODE_OFF)) begin
        presc_reg <= '0;
        phase_reg <= '0;
      end else begin
        presc_reg <= tick ? '0 : presc_reg + 1'b1;
        if (tick) begin
          if (mode_reg == MODE_HAZ)
            phase_reg <= (phase_reg == '0) ? PHW'(1) : '0;
          else
            phase_reg <= (phase_reg == PHASE_MAX) ? '0 : phase_reg + 1'b1;
        end
      end
    end
  end

  // Outward sweep: the lowest `phase` lamps are lit.
  generate
    for (genvar gi = 0; gi < N_SIDE; gi++) begin : g_sweep
      assign sweep[gi] = (phase_reg > PHW'(gi));
    end
  endgenerate

  assign all_on = ((mode_reg == MODE_HAZ) && (phase_reg != '0)) ? '1 : '0;

  always_comb begin
    l_pat = all_on;
    r_pat = all_on;
    if (mode_reg == MODE_LEFT)  l_pat = sweep;
    if (mode_reg == MODE_RIGHT) r_pat = sweep;
  end

endmodule

// File: rtl/tail_light_ctrl.sv
// ----------------------------------------------------------------------------
// tail_light_ctrl
//   Rear-lamp controller. It has three parts:
//   - A brake FSM with a hold counter. This keeps the brake lamps lit for
//     HOLD_CYCLES after the pedal is released.
//   - A turn_sequencer that supplies the sweep and hazard patterns.
//   - Registered lamp outputs. While braking, each side bank shows the
//     inverted pattern and the centre bank is fully lit.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   brake         brake pedal (already synchronised)
//   left_turn     left indicator request
//   right_turn    right indicator request
//   hazard        hazard request
//   l_lights      left bank, bit0 = innermost lamp
//   c_lights      centre bank
//   r_lights      right bank, bit0 = innermost lamp
//   brake_active  combinational brake-lamp enable (from state and brake)
// ----------------------------------------------------------------------------
module tail_light_ctrl
  import tail_light_pkg::*;
#(
  parameter int N_SIDE      = 3,
  parameter int N_CENTER    = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int STEP_DIV    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                brake,
  input  logic                left_turn,
  input  logic                right_turn,
  input  logic                hazard,
  output logic [N_SIDE-1:0]   l_lights,
  output logic [N_CENTER-1:0] c_lights,
  output logic [N_SIDE-1:0]   r_lights,
  output logic                brake_active
);

  localparam int HW = cnt_width(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  logic [1:0]        state_reg, state_next;
  logic [HW-1:0]     hold_cnt_reg, hold_cnt_next;
  logic [N_SIDE-1:0] l_pat, r_pat;

  turn_sequencer #(
    .N_SIDE   (N_SIDE),
    .STEP_DIV (STEP_DIV)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .left_turn  (left_turn),
    .right_turn (right_turn),
    .hazard     (hazard),
    .l_pat      (l_pat),
    .r_pat      (r_pat)
  );

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (brake) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!brake) begin
          state_next    = ST_HOLD;
          hold_cnt_next = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (brake)                   state_next    = ST_ACTIVE;
        else if (hold_cnt_reg == '0) state_next    = ST_IDLE;
        else                         hold_cnt_next = hold_cnt_reg - 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Mealy output: the pedal lights the lamps in the same cycle. The hold
  // extends them for the release cycle plus HOLD_CYCLES-1 more cycles.
  assign brake_active = brake
                      || (state_reg == ST_ACTIVE)
                      || ((state_reg == ST_HOLD) && (hold_cnt_reg != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      l_lights     <= '0;
      c_lights     <= '0;
      r_lights     <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      if (brake_active) begin
        l_lights <= ~l_pat;
        r_lights <= ~r_pat;
        c_lights <= '1;
      end else begin
        l_lights <= l_pat;
        r_lights <= r_pat;
        c_lights <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tail_light_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tail_light_ctrl
//   Drives two instances from the same inputs:
//   - one with the default parameters;
//   - one with the minimum parameters (1 side lamp, 1 centre lamp, 1 hold
//     cycle, step every clock).
//   Each instance is checked against a per-instance model.
//   - The model tracks the length of the current brake-released run.
//   - It tracks the length of the current mode run.
//   - It computes the expected lamps arithmetically from those run lengths.
// ----------------------------------------------------------------------------
module tb_tail_light_ctrl;

  localparam int BIG = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, brake, left_turn, right_turn, hazard;

  logic [2:0] l_a, r_a;
  logic [1:0] c_a;
  logic       ba_a;
  logic [0:0] l_b, r_b, c_b;
  logic       ba_b;

  tail_light_ctrl dut_a (
    .clk          (clk),
    .rst          (rst),
    .brake        (brake),
    .left_turn    (left_turn),
    .right_turn   (right_turn),
    .hazard       (hazard),
    .l_lights     (l_a),
    .c_lights     (c_a),
    .r_lights     (r_a),
    .brake_active (ba_a)
  );

  tail_light_ctrl #(
    .N_SIDE      (1),
    .N_CENTER    (1),
    .HOLD_CYCLES (1),
    .STEP_DIV    (1)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .brake        (brake),
    .left_turn    (left_turn),
    .right_turn   (right_turn),
    .hazard       (hazard),
    .l_lights     (l_b),
    .c_lights     (c_b),
    .r_lights     (r_b),
    .brake_active (ba_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int ns_p[2]   = '{3, 1};
  int nc_p[2]   = '{2, 1};
  int hold_p[2] = '{2, 1};
  int div_p[2]  = '{4, 1};

  // Model state: cycles since the pedal was last high, the current
  // requested mode, and how many cycles that mode has been requested.
  int low_run[2];
  int run_mode[2];
  int run_k[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Modes: 0 off, 1 left, 2 right, 3 hazard
  function automatic int req_mode(input logic l, input logic r, input logic h);
    if (h || (l && r)) return 3;
    if (l) return 1;
    if (r) return 2;
    return 0;
  endfunction

  // Pattern shown by one side after mode has been requested for k cycles.
  function automatic int side_pat(input int mode, input int side, input int k,
                                  input int ns, input int div);
    int steps;
    if (k == 0 || mode == 0) return 0;
    steps = (k - 1) / div;
    if (mode == 3) return (steps % 2 == 1) ? ((1 << ns) - 1) : 0;
    if (mode == side) return (1 << (steps % (ns + 1))) - 1;
    return 0;
  endfunction

  task automatic do_cycle(input logic b, input logic l, input logic r,
                          input logic h, input logic rs);
    int  m;
    int  exp_l[2], exp_r[2], exp_c[2];
    logic act[2];
    brake = b; left_turn = l; right_turn = r; hazard = h; rst = rs;
    #1;
    m = req_mode(l, r, h);
    for (int i = 0; i < 2; i++) begin
      int mask, pl, pr, nxt_low;
      mask    = (1 << ns_p[i]) - 1;
      pl      = side_pat(run_mode[i], 1, run_k[i], ns_p[i], div_p[i]);
      pr      = side_pat(run_mode[i], 2, run_k[i], ns_p[i], div_p[i]);
      nxt_low = b ? 0 : low_run[i] + 1;
      act[i]  = b || (nxt_low <= hold_p[i]);
      exp_l[i] = act[i] ? (~pl & mask) : pl;
      exp_r[i] = act[i] ? (~pr & mask) : pr;
      exp_c[i] = act[i] ? ((1 << nc_p[i]) - 1) : 0;
      if (rs) begin
        exp_l[i] = 0; exp_r[i] = 0; exp_c[i] = 0;
        low_run[i] = BIG; run_mode[i] = 0; run_k[i] = 0;
      end else begin
        low_run[i] = (nxt_low > BIG) ? BIG : nxt_low;
        if (m == run_mode[i]) run_k[i]++;
        else begin
          run_mode[i] = m;
          run_k[i]    = 1;
        end
      end
    end
    if (!rs) begin
      check("brake_active_a", {31'b0, ba_a}, {31'b0, act[0]});
      check("brake_active_b", {31'b0, ba_b}, {31'b0, act[1]});
    end
    @(posedge clk);
    #1;
    check("l_lights_a", 32'(l_a), exp_l[0]);
    check("c_lights_a", 32'(c_a), exp_c[0]);
    check("r_lights_a", 32'(r_a), exp_r[0]);
    check("l_lights_b", 32'(l_b), exp_l[1]);
    check("c_lights_b", 32'(c_b), exp_c[1]);
    check("r_lights_b", 32'(r_b), exp_r[1]);
    $display("cycle t=%0t rst=%b brk=%b l=%b r=%b h=%b | A l=%b c=%b r=%b | B l=%b c=%b r=%b",
             $time, rs, b, l, r, h, l_a, c_a, r_a, l_b, c_b, r_b);
  endtask

  task automatic run(input int n, input logic b, input logic l,
                     input logic r, input logic h);
    for (int j = 0; j < n; j++) do_cycle(b, l, r, h, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      low_run[i] = BIG; run_mode[i] = 0; run_k[i] = 0;
    end
    rst = 1'b1; brake = 1'b0; left_turn = 1'b0; right_turn = 1'b0; hazard = 1'b0;

    // Reset state
    do_cycle(0, 0, 0, 0, 1);
    do_cycle(0, 0, 0, 0, 1);
    run(2, 0, 0, 0, 0);

    // Brake held, then released: hold window and light clear-down
    run(5, 1, 0, 0, 0);
    run(5, 0, 0, 0, 0);

    // Re-press during the hold window
    run(4, 1, 0, 0, 0);
    run(1, 0, 0, 0, 0);
    run(3, 1, 0, 0, 0);
    run(5, 0, 0, 0, 0);

    // Left sweep, no brake
    run(20, 0, 1, 0, 0);
    run(3, 0, 0, 0, 0);

    // Left sweep with brake
    run(20, 1, 1, 0, 0);
    run(4, 0, 0, 0, 0);

    // Right sweep
    run(18, 0, 0, 1, 0);

    // Both indicators, then hazard alone (same mode, no restart)
    run(12, 0, 1, 1, 0);
    run(12, 0, 0, 0, 1);
    run(3, 0, 0, 0, 0);

    // Reset mid-sweep, then the sweep restarts
    run(9, 0, 1, 0, 0);
    do_cycle(0, 1, 0, 0, 1);
    run(10, 0, 1, 0, 0);

    // Reset mid-hold
    run(4, 1, 0, 0, 0);
    run(1, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1);
    run(4, 0, 0, 0, 0);

    // Randomised runs
    for (int t = 0; t < 40; t++) begin
      logic b, l, r, h, rs;
      int   len;
      b   = 1'($urandom_range(0, 1));
      l   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 2) == 0);
      h   = 1'($urandom_range(0, 4) == 0);
      rs  = 1'($urandom_range(0, 14) == 0);
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) do_cycle(b, l, r, h, rs && (j == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
